// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue.
package if_id_queue_pkg;
  localparam logic [31:0] ZeroWord        = 32'h0000_0000;
  localparam logic        BranchEnable    = 1'b1;
  localparam logic        NoStop          = 1'b0;
  localparam int          IF_ID_STALL_BIT = 1;
  localparam int          ID_STALL_BIT    = 2;
  localparam int          IfIdQueueDepth  = 4;
endpackage

// File: rtl/if_id_fifo_mem.sv
// Circular instruction buffer for the IF/ID queue: storage, pointers and
// occupancy. The caller guarantees no push when full and no pop when empty.
module if_id_fifo_mem #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Storage is written only on push; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  // Pointer and occupancy next state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PW'(1);
      if (pop_i)  rptr_d = rptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/if_id_queue.sv
// IF/ID stage: DEPTH-entry instruction queue plus a registered slot feeding ID.
// Optional feature macro IF_ID_CUT_THROUGH_EN: when defined, an instruction
// arriving at an empty queue on an advancing cycle goes straight to the slot.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = IfIdQueueDepth
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic [INST_W-1:0]          inst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       ex_branch_flag_i,
  input  logic [4:0]                 stalled_i,
  output logic [ADDR_W-1:0]          pc_o,
  output logic [INST_W-1:0]          inst_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int W = ADDR_W + INST_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic [W-1:0]      head;
  logic              full, empty;
  logic              push, flush, advance, bubble, cut, fifo_push, fifo_pop;
  logic              unused_stall_bits;

  assign unused_stall_bits = ^{stalled_i[4:3], stalled_i[0]};

  assign ready_o = ~full;
  assign push    = valid_i & ready_o;
  assign flush   = (ex_branch_flag_i == BranchEnable);
  assign advance = (stalled_i[IF_ID_STALL_BIT] == NoStop);
  assign bubble  = !advance && (stalled_i[ID_STALL_BIT] == NoStop);

`ifdef IF_ID_CUT_THROUGH_EN
  assign cut = !flush && advance && empty && push;
`else
  assign cut = 1'b0;
`endif

  // A flush drops any same-cycle push; a cut-through word bypasses storage.
  assign fifo_push = push && !flush && !cut;
  assign fifo_pop  = !flush && advance && !empty;

  if_id_fifo_mem #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (flush),
    .wdata_i ({pc_i, inst_i}),
    .rdata_o (head),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // Output slot priority: flush, advance (pop / cut-through / empty), bubble, hold.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      inst_d  = '0;
      valid_d = 1'b0;
    end else if (advance) begin
      if (!empty) begin
        pc_d    = head[W-1:INST_W];
        inst_d  = head[INST_W-1:0];
        valid_d = 1'b1;
      end else if (cut) begin
        pc_d    = pc_i;
        inst_d  = inst_i;
        valid_d = 1'b1;
      end else begin
        pc_d    = '0;
        inst_d  = '0;
        valid_d = 1'b0;
      end
    end else if (bubble) begin
      pc_d    = '0;
      inst_d  = '0;
      valid_d = 1'b0;
    end
  end

  // Output slot register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 4;
`ifdef IF_ID_CUT_THROUGH_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i, inst_i;
  logic        valid_i;
  logic        ready_o;
  logic        ex_branch_flag_i;
  logic [4:0]  stalled_i;
  logic [31:0] pc_o, inst_o;
  logic        valid_o;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mq[$];
  logic [31:0] m_pc, m_inst;
  logic        m_v;
  logic [31:0] nxt_pc, nxt_inst;

  always #5 clk = ~clk;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_i             (pc_i),
    .inst_i           (inst_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .ex_branch_flag_i (ex_branch_flag_i),
    .stalled_i        (stalled_i),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .valid_o          (valid_o),
    .count_o          (count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    {32'h0, pc_o},   {32'h0, m_pc});
    chk({tag, ".inst"},  {32'h0, inst_o}, {32'h0, m_inst});
    chk({tag, ".valid"}, {63'h0, valid_o}, {63'h0, m_v});
    chk({tag, ".count"}, {61'h0, count_o}, 64'(mq.size()));
    chk({tag, ".ready"}, {63'h0, ready_o}, {63'h0, (mq.size() != DEPTH)});
  endtask

  task automatic model_clear();
    mq.delete();
    m_pc = '0; m_inst = '0; m_v = 1'b0;
  endtask

  // One clock: advance the reference model at the edge, compare at the negedge.
  task automatic cyc(input string tag);
    logic        push;
    logic [63:0] e;
    @(posedge clk);
    push = valid_i && (mq.size() != DEPTH);
    if (ex_branch_flag_i) begin
      model_clear();
    end else begin
      if (!stalled_i[1]) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          m_pc = e[63:32]; m_inst = e[31:0]; m_v = 1'b1;
          if (push) mq.push_back({pc_i, inst_i});
        end else if (CT && push) begin
          m_pc = pc_i; m_inst = inst_i; m_v = 1'b1;
        end else begin
          m_pc = '0; m_inst = '0; m_v = 1'b0;
          if (push) mq.push_back({pc_i, inst_i});
        end
      end else if (!stalled_i[2]) begin
        m_pc = '0; m_inst = '0; m_v = 1'b0;
        if (push) mq.push_back({pc_i, inst_i});
      end else if (push) begin
        mq.push_back({pc_i, inst_i});
      end
      if (push) begin
        nxt_pc   = nxt_pc + 32'd4;
        nxt_inst = $urandom;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int          lat;
    logic [31:0] last_pc;
    logic [2:0]  cnt_ref;
    bit          seen;
    int          r;

    rst_n = 1'b0; valid_i = 1'b0; pc_i = '0; inst_i = '0;
    ex_branch_flag_i = 1'b0; stalled_i = 5'b0;
    nxt_pc = 32'h100; nxt_inst = 32'h0000_0013;
    model_clear();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: first-instruction latency
    pc_i = 32'h100; inst_i = 32'h0000_0013; valid_i = 1'b1;
    cyc("t1.push");
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 5) begin
      cyc("t1.wait");
      lat++;
    end
    chk("t1.latency", 64'(lat), CT ? 64'd1 : 64'd2);
    chk("t1.pc", {32'h0, pc_o}, 64'h100);

    // Test 2: fill under full stall, then drain in order
    ex_branch_flag_i = 1'b1; cyc("t2.flush"); ex_branch_flag_i = 1'b0;
    stalled_i = 5'b00110; nxt_pc = 32'h100;
    for (int i = 0; i < DEPTH; i++) begin
      valid_i = 1'b1; pc_i = nxt_pc; inst_i = nxt_inst;
      cyc("t2.fill");
    end
    valid_i = 1'b0;
    chk("t2.count", {61'h0, count_o}, 64'(DEPTH));
    chk("t2.ready", {63'h0, ready_o}, 64'd0);
    stalled_i = 5'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cyc("t2.drain");
      chk("t2.pcseq", {32'h0, pc_o}, 64'(32'h100 + 32'(4 * i)));
    end

    // Test 3: bubble keeps queued entries
    stalled_i = 5'b00110; nxt_pc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1; pc_i = nxt_pc; inst_i = nxt_inst;
      cyc("t3.fill");
    end
    valid_i = 1'b0; stalled_i = 5'b0;
    cyc("t3.pop");
    stalled_i = 5'b00010;
    cyc("t3.bubble");
    chk("t3.bubble_valid", {63'h0, valid_o}, 64'd0);
    chk("t3.kept", {61'h0, count_o}, 64'd1);

    // Test 4: flush with count 3 and a same-cycle push
    stalled_i = 5'b00110;
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1; pc_i = nxt_pc; inst_i = nxt_inst;
      cyc("t4.fill");
    end
    chk("t4.count3", {61'h0, count_o}, 64'd3);
    valid_i = 1'b1; pc_i = 32'hDEAD_0000; inst_i = 32'hBAD;
    ex_branch_flag_i = 1'b1;
    cyc("t4.flush");
    ex_branch_flag_i = 1'b0; valid_i = 1'b0; stalled_i = 5'b0;
    chk("t4.count0", {61'h0, count_o}, 64'd0);
    cyc("t4.after");
    chk("t4.dropped", {63'h0, valid_o}, 64'd0);

    // Test 5: continuous streaming across pointer wrap
    nxt_pc = 32'h400; seen = 1'b0; last_pc = '0; cnt_ref = '0;
    for (int i = 0; i < 3 * DEPTH + 2; i++) begin
      valid_i = 1'b1; pc_i = nxt_pc; inst_i = nxt_inst;
      cyc("t5.stream");
      if (i == 2) cnt_ref = count_o;
      if (i > 2) chk("t5.count_const", {61'h0, count_o}, {61'h0, cnt_ref});
      if (valid_o) begin
        if (seen) chk("t5.contig", {32'h0, pc_o}, {32'h0, last_pc + 32'd4});
        seen = 1'b1; last_pc = pc_o;
      end
    end
    valid_i = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      pc_i = nxt_pc; inst_i = nxt_inst;
      r = $urandom_range(0, 9);
      stalled_i = (r < 5) ? 5'b00000 : (r < 7) ? 5'b00110 : (r < 9) ? 5'b00010 : 5'b00100;
      ex_branch_flag_i = ($urandom_range(0, 15) == 0);
      cyc("rand");
    end
    ex_branch_flag_i = 1'b0;

    // Test 6: asynchronous reset with two entries queued
    ex_branch_flag_i = 1'b1; stalled_i = 5'b0; valid_i = 1'b0;
    cyc("t6.flush"); ex_branch_flag_i = 1'b0;
    stalled_i = 5'b00110;
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1; pc_i = nxt_pc; inst_i = nxt_inst;
      cyc("t6.fill");
    end
    valid_i = 1'b0;
    chk("t6.count2", {61'h0, count_o}, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.async_valid", {63'h0, valid_o}, 64'd0);
    chk("t6.async_count", {61'h0, count_o}, 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1; stalled_i = 5'b0;
    cyc("t6.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF/ID stage between fetch (pc_reg / cpu_ahb_if) and decode.
- Replaces the single-entry IF/ID register with a DEPTH-entry instruction queue plus a registered output slot feeding ID.
- Adds a valid/ready handshake toward fetch, an explicit valid toward ID, branch flush, and ctrl stall/bubble handling.
- Fetch can run ahead of decode while ID stalls.

Parameters:
- ADDR_W, 32, instruction address width.
- INST_W, 32, instruction word width.
- DEPTH, 4, queue entries; power of two, ≥2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  async reset, active-low
- pc_i  in  ADDR_W  fetched instruction address
- inst_i  in  INST_W  fetched instruction
- valid_i  in  1  pc_i/inst_i valid this cycle
- ready_o  out  1  queue can accept; push = valid_i & ready_o
- ex_branch_flag_i  in  1  branch taken in EX; flush
- stalled_i  in  5  ctrl stall vector; bit1 = IF/ID hold, bit2 = ID hold
- pc_o  out  ADDR_W  to ID
- inst_o  out  INST_W  to ID
- valid_o  out  1  pc_o/inst_o hold a real instruction
- count_o  out  $clog2(DEPTH+1)  queue occupancy, excluding the output slot

Behaviour:
Clock and reset:
- One clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset state: pc_o = 0, inst_o = 0, valid_o = 0, count_o = 0, read and write pointers = 0.
- ready_o is combinational: count_o != DEPTH. It is therefore 1 directly after reset.
- An rst_n assertion mid-operation discards all entries immediately.

Queue:
- Circular buffer; write and read pointers wrap modulo DEPTH.
- Push: valid_i & ready_o. Writes {pc_i, inst_i} at wptr.
- There is no push when full, even if a pop happens in the same cycle (no full-bypass).
- Simultaneous push and pop leaves count unchanged.

Output slot, evaluated each posedge in this priority:
1. ex_branch_flag_i = 1: output slot <- zeros, valid_o <- 0, count <- 0, pointers reset. Any push in this cycle is dropped.
2. stalled_i[1] = 0 (advance):
   - If count > 0: pop the head into the slot, valid_o <- 1.
   - Else: cut-through, see Optional Feature.
   - Else: slot <- zeros, valid_o <- 0.
3. stalled_i[1] = 1 and stalled_i[2] = 0: bubble. Slot <- zeros, valid_o <- 0. No pop. Pushes are still accepted.
4. Otherwise: hold slot and valid_o. No pop. Pushes are still accepted.

Latency and ordering:
- Minimum fetch-to-ID latency is 1 cycle with cut-through, 2 cycles without.
- Order is strictly FIFO; no instruction is dropped except by flush or reset.
- valid_i = 1 while ready_o = 0: no push. Fetch must hold its data.

Optional Feature:
- Macro: IF_ID_CUT_THROUGH_EN.
- Defined: when count = 0, a push occurs, and the cycle advances with no flush, {pc_i, inst_i} loads directly into the output slot (valid_o <- 1) and is not written to the queue. Latency is 1 cycle, matching the legacy single-register behaviour.
- Undefined: every instruction passes through the queue, giving a 2-cycle minimum latency. ready_o timing is unchanged. This configuration is for timing-critical builds.

Decomposition:
- yadan_defs.v holds:
  - ZeroWord.
  - BranchEnable, NoStop.
  - Stall-vector bit indices IF_ID_STALL_BIT = 1 and ID_STALL_BIT = 2.
  - Default queue depth IfIdQueueDepth.
- Natural sub-module: if_id_fifo_mem. It contains the storage array, wptr/rptr, count, and full/empty, with push/pop/clear inputs. if_id_queue keeps the output slot and the priority logic.

Test Plan:
1. Reset, then push pc = 0x100 / inst = 0x00000013 with no stalls -> with CUT_THROUGH_EN, valid_o = 1 and pc_o = 0x100 at the next edge. Without it, this happens one edge later.
2. Hold stalled_i = 5'b00110 and push 4 instructions (0x100–0x10C) -> count_o = 4, ready_o = 0, output slot held. Release the stall -> pc_o steps 0x100, 0x104, 0x108, 0x10C on consecutive edges.
3. With stalled_i = 5'b00010 -> next edge gives valid_o = 0, inst_o = 0, pc_o = 0 (bubble). The queue retains its entries.
4. With count = 3 plus a push in the same cycle, assert ex_branch_flag_i -> next edge gives count_o = 0, valid_o = 0. The pushed entry is absent afterwards.
5. Continuous push and pop for 3·DEPTH cycles across pointer wrap -> output pc sequence contiguous, count constant.
6. Deassert rst_n asynchronously with count = 2 -> valid_o = 0 and count_o = 0 immediately, without waiting for clk.
